// File: rtl/isa_pkg.sv
// ISA constants shared by the fetch stage
// and the ID-stage control unit.
package isa_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  localparam logic [5:0] OP_NOP = 6'b000000;
  localparam logic [5:0] OP_BEZ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_JMP = 6'b000110;
  localparam logic [5:0] OP_SWP = 6'b111111;

  function automatic logic [5:0] opcode_of(
    input logic [INSTR_W-1:0] instr
  );
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: control/redirect/program-load
// inputs and the IF/ID register outputs.
interface if_stage_if #(
  parameter int ADDR_W = 32
);

  logic              freeze;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [31:0]       prog_data;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] if_id_pc;
  logic [31:0]       if_id_instr;
  logic              if_id_valid;
  logic [31:0]       fetch_cnt;

  modport master (
    input  freeze, branch_taken, branch_target,
    input  prog_we, prog_addr, prog_data,
    output pc, if_id_pc, if_id_instr,
    output if_id_valid, fetch_cnt
  );

  modport slave (
    output freeze, branch_taken, branch_target,
    output prog_we, prog_addr, prog_data,
    input  pc, if_id_pc, if_id_instr,
    input  if_id_valid, fetch_cnt
  );

endinterface

// File: rtl/instr_mem.sv
// Instruction memory: sync write, async read,
// so a same-cycle write/read returns the old word.
module instr_mem
  import isa_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem, IF/ID register
// and fetch counter; redirect beats freeze.
module if_stage
  import isa_pkg::*;
#(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 32
) (
  input logic        clk,
  input logic        rst_n,
  if_stage_if.master bus
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  ipc_q, ipc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [INSTR_W-1:0] rdata;
  logic [ADDR_W-1:0]  pc_inc;
  logic               unused_ok;

  assign unused_ok = ^{bus.branch_target[1:0],
                       bus.prog_addr[1:0]};

  instr_mem #(
    .DEPTH (IMEM_DEPTH)
  ) u_imem (
    .clk   (clk),
    .we    (bus.prog_we),
    .waddr (bus.prog_addr[IW+1:2]),
    .wdata (bus.prog_data),
    .raddr (pc_q[IW+1:2]),
    .rdata (rdata)
  );

  assign pc_inc = pc_q + PC_STEP;

  always_comb begin
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      bus.branch_taken: begin
        pc_d    = {bus.branch_target[ADDR_W-1:2], 2'b00};
        ipc_d   = '0;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      (!bus.branch_taken && bus.freeze): begin
      end
      (!bus.branch_taken && !bus.freeze): begin
        pc_d    = pc_inc;
        ipc_d   = pc_inc;
        instr_d = rdata;
        valid_d = 1'b1;
        cnt_d   = cnt_q + 32'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= '0;
      ipc_q   <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.if_id_pc    = ipc_q;
  assign bus.if_id_instr = instr_q;
  assign bus.if_id_valid = valid_q;
  assign bus.fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed scenarios
// then random traffic against a behavioural model.
module tb_if_stage;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  if_stage_if #(.ADDR_W(32)) bus ();

  if_stage #(
    .IMEM_DEPTH (256),
    .ADDR_W     (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        chk;
    logic        ipc_chk;
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
  logic        m_valid, m_ipc_known;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs
  // must look like after the following posedge.
  task automatic step(input logic rst, input logic frz,
                      input logic br, input logic [31:0] tgt,
                      input logic we, input logic [31:0] wa,
                      input logic [31:0] wd,
                      input logic chk = 1'b1);
    exp_t e;
    @(negedge clk);
    rst_n             = rst;
    bus.freeze        = frz;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.prog_we       = we;
    bus.prog_addr     = wa;
    bus.prog_data     = wd;
    if (!rst) begin
      m_pc = 0; m_ipc = 0; m_instr = 0;
      m_valid = 0; m_cnt = 0; m_ipc_known = 1;
    end else if (br) begin
      m_pc = tgt & ~32'h3;
      m_instr = 0; m_valid = 0; m_ipc_known = 0;
    end else if (!frz) begin
      m_instr = m_mem[(m_pc / 4) % 256];
      m_ipc = m_pc + 4;
      m_pc = m_pc + 4;
      m_valid = 1; m_cnt = m_cnt + 1;
      m_ipc_known = 1;
    end
    if (we) m_mem[(wa / 4) % 256] = wd;
    e.chk = chk; e.ipc_chk = m_ipc_known;
    e.pc = m_pc; e.ipc = m_ipc; e.instr = m_instr;
    e.valid = m_valid; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          check("pc", bus.pc, e.pc);
          check("if_id_instr", bus.if_id_instr, e.instr);
          check("if_id_valid", 32'(bus.if_id_valid),
                32'(e.valid));
          check("fetch_cnt", bus.fetch_cnt, e.cnt);
          if (e.ipc_chk)
            check("if_id_pc", bus.if_id_pc, e.ipc);
        end
      end
    end
  end

  initial begin : stim
    logic [31:0] w;
    rst_n = 1'b0;
    bus.freeze = 0; bus.branch_taken = 0;
    bus.branch_target = 0; bus.prog_we = 0;
    bus.prog_addr = 0; bus.prog_data = 0;

    for (int i = 0; i < 256; i++) begin
      case (i)
        0: w = 32'h0400_0000;
        1: w = 32'h0C00_0000;
        2: w = 32'h1400_0000;
        3: w = 32'h1800_0000;
        default: w = $urandom;
      endcase
      step(1, 0, 0, 0, 1, 32'(i * 4), w, 1'b0);
    end

    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    run(4);

    step(1, 0, 1, 32'h0, 1, 32'h8, 32'hFC00_0000);
    run(3);
    step(1, 1, 0, 0, 0, 0, 0);
    run(2);

    step(1, 1, 1, 32'h41, 0, 0, 0);
    run(2);

    step(1, 0, 1, 32'h3FC, 0, 0, 0);
    run(3);

    step(1, 0, 1, 32'h20, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h20, 32'hDEAD_BEEF);
    step(1, 0, 1, 32'h20, 0, 0, 0);
    run(2);

    run(3);
    step(0, 1, 1, 32'h80, 0, 0, 0);
    run(3);

    for (int i = 0; i < 3000; i++) begin
      logic r, f, b, we;
      r  = ($urandom_range(0, 99) >= 2);
      f  = ($urandom_range(0, 99) < 30);
      b  = ($urandom_range(0, 99) < 10);
      we = r && ($urandom_range(0, 99) < 15);
      step(r, f, b, $urandom, we, $urandom, $urandom);
    end

    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d left, expected 0",
               exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
